// File: rtl/left_barrel_shifter_pipe.sv
// Pipelined logical left barrel shifter: stage k shifts by 2^k, valid/ready on both ends.
// Define LBS_ROTATE_EN to add a rotate-left mode carried alongside each operand.
module left_barrel_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shift,
`ifdef LBS_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic [SHW:0]     count
);

  logic [SHW-1:0] v_all;
  logic [SHW-1:0] rdy;
  logic           in_xfer;
  logic           out_xfer;

  // A stage may advance if it is empty or anything downstream can make room.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = SHW - 1; k >= 0; k--) begin
      r      = r | ~v_all[k];
      rdy[k] = r;
    end
  end

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    localparam int DIST = 1 << gi;

    logic             v_reg;
    logic [WIDTH-1:0] d_reg;
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             src_bit;
    logic [WIDTH-1:0] moved;
`ifdef LBS_ROTATE_EN
    logic             src_rot;
`endif

    if (gi == 0) begin : g_src
      assign src_v   = in_valid;
      assign src_d   = A;
      assign src_bit = shift[0];
`ifdef LBS_ROTATE_EN
      assign src_rot = rotate;
`endif
    end else begin : g_src
      assign src_v   = g_stage[gi-1].v_reg;
      assign src_d   = g_stage[gi-1].d_reg;
      assign src_bit = g_stage[gi-1].g_ctl.sh_reg[gi];
`ifdef LBS_ROTATE_EN
      assign src_rot = g_stage[gi-1].g_ctl.rot_reg;
`endif
    end

`ifdef LBS_ROTATE_EN
    assign moved = src_rot ? ((src_d << DIST) | (src_d >> (WIDTH - DIST)))
                           : (src_d << DIST);
`else
    assign moved = src_d << DIST;
`endif

    // Only the shift bits still ahead of this stage are carried forward.
    if (gi < SHW - 1) begin : g_ctl
      logic [SHW-1:gi+1] sh_reg;
      logic [SHW-1:gi+1] rest_in;
`ifdef LBS_ROTATE_EN
      logic              rot_reg;
`endif
      if (gi == 0) begin : g_rest
        assign rest_in = shift[SHW-1:1];
      end else begin : g_rest
        assign rest_in = g_stage[gi-1].g_ctl.sh_reg[SHW-1:gi+1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_reg  <= '0;
`ifdef LBS_ROTATE_EN
          rot_reg <= 1'b0;
`endif
        end else if (rdy[gi] && src_v) begin
          sh_reg  <= rest_in;
`ifdef LBS_ROTATE_EN
          rot_reg <= src_rot;
`endif
        end
      end
    end

    // Data only moves with a real operand so B keeps its last value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        d_reg <= '0;
      end else if (rdy[gi]) begin
        v_reg <= src_v;
        if (src_v) begin
          d_reg <= src_bit ? moved : src_d;
        end
      end
    end

    assign v_all[gi] = v_reg;
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_all[SHW-1];
  assign B         = g_stage[SHW-1].d_reg;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      count <= count - 1'b1;
    end
  end

endmodule
